// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage definitions: opcodes, funct3 encodings, LSU states
// and the access-fault decode used by the load/store unit.
package riscv_mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } lsu_state_t;

    // Illegal size encoding or an address not aligned to the access size.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic bad_f3;
        logic misalign;
        if (is_store) begin
            bad_f3 = (funct3 >= 3'b011);
        end else begin
            bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return bad_f3 || misalign;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-stage request, response and RAM port bundle. The slave modport is
// the load/store unit; the master modport is the pipeline plus RAM side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_valid;
    logic [6:0]        iOpcode;
    logic [2:0]        iFunct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_stall;
    logic              o_done;
    logic [31:0]       o_rdata;
    logic              o_fault;
    logic              o_RAM_CE;
    logic              o_RAM_RD;
    logic              o_RAM_WR;
    logic [ADDR_W-1:0] o_RAM_ADDR;
    logic [31:0]       i_RAM_DATA_RD;
    logic [31:0]       o_RAM_DATA_WR;

    modport slave (
        input  i_valid, iOpcode, iFunct3, i_addr, i_wdata, i_RAM_DATA_RD,
        output o_stall, o_done, o_rdata, o_fault,
        output o_RAM_CE, o_RAM_RD, o_RAM_WR, o_RAM_ADDR, o_RAM_DATA_WR
    );

    modport master (
        output i_valid, iOpcode, iFunct3, i_addr, i_wdata, i_RAM_DATA_RD,
        input  o_stall, o_done, o_rdata, o_fault,
        input  o_RAM_CE, o_RAM_RD, o_RAM_WR, o_RAM_ADDR, o_RAM_DATA_WR
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts and extends sub-word loads from a
// RAM word and merges sub-word store data into it for read-modify-write.
module lsu_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_val_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/halfword lane, then extend per funct3.
    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        load_val_o = 32'h0;
        case (lane_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        case (funct3_i)
            F3_B:    load_val_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val_o = {24'h0, byte_sel};
            F3_H:    load_val_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val_o = {16'h0, half_sel};
            F3_W:    load_val_o = rword_i;
            default: load_val_o = 32'h0;
        endcase
    end

    // Overlay store data onto the captured word; untouched lanes pass through.
    always_comb begin
        merged_o = rword_i;
        case (funct3_i)
            F3_B: begin
                case (lane_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
            end
            default: merged_o = rword_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine driving a single word-wide RAM port without
// byte enables; sub-word stores go through read-modify-write.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 1,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    load_store_unit_if.slave   bus
);

    localparam int unsigned CntW = (RAM_RD_LAT > 0) ? $clog2(RAM_RD_LAT + 1) : 1;

    lsu_state_t        state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;

    logic              accept;
    logic              req_store;
    logic              req_fault;
    logic              stall;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign req_store = (bus.iOpcode == OP_STORE);
    assign accept    = RST_N && bus.i_valid &&
                       ((bus.iOpcode == OP_LOAD) || (bus.iOpcode == OP_STORE));
    assign req_fault = access_fault(req_store, bus.iFunct3, bus.i_addr[1:0]);

    lsu_lane_align u_lane_align (
        .rword_i    (word_q),
        .lane_i     (addr_q[1:0]),
        .funct3_i   (f3_q),
        .wdata_i    (wdata_q),
        .load_val_o (load_val),
        .merged_o   (merged)
    );

    // Next-state and request latching; stall is asserted from accept to last access.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        stall      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall      = 1'b1;
                    is_store_d = req_store;
                    f3_d       = bus.iFunct3;
                    addr_d     = bus.i_addr;
                    wdata_d    = bus.i_wdata;
                    fault_d    = req_fault;
                    cnt_d      = CntW'(RAM_RD_LAT);
                    if (req_fault) begin
                        state_d = StDone;
                    end else if (req_store && (bus.iFunct3 == F3_W)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    word_d  = bus.i_RAM_DATA_RD;
                    state_d = is_store_q ? StWrite : StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWrite: begin
                stall   = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            word_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
        end
    end

    // RAM port and response outputs decoded from registered state.
    always_comb begin
        bus.o_stall       = stall;
        bus.o_done        = (state_q == StDone);
        bus.o_fault       = (state_q == StDone) && fault_q;
        bus.o_rdata       = ((state_q == StDone) && !is_store_q && !fault_q) ? load_val : 32'h0;
        bus.o_RAM_RD      = (state_q == StRead);
        bus.o_RAM_WR      = (state_q == StWrite);
        bus.o_RAM_CE      = (state_q == StRead) || (state_q == StWrite);
        bus.o_RAM_ADDR    = '0;
        bus.o_RAM_DATA_WR = 32'h0;
        if ((state_q == StRead) || (state_q == StWrite)) begin
            bus.o_RAM_ADDR = {addr_q[ADDR_W-1:2], 2'b00};
        end
        if (state_q == StWrite) begin
            bus.o_RAM_DATA_WR = (f3_q == F3_W) ? wdata_q : merged;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural one-cycle-latency RAM
// and a scoreboard of expected completion results.
module tb_load_store_unit;
    import riscv_mem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [31:0] mem [int unsigned];
    logic [31:0] ram_rdata_q = 32'h0;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(
        .RAM_RD_LAT (1),
        .ADDR_W     (32)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    assign bus.i_RAM_DATA_RD = ram_rdata_q;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a >> 2)) return mem[a >> 2];
        return 32'h0;
    endfunction

    // Read data becomes valid one cycle after RD is first sampled.
    always @(posedge clk) begin
        if (bus.o_RAM_RD) ram_rdata_q <= mem_rd(bus.o_RAM_ADDR);
    end

    always @(posedge clk) begin
        if (bus.o_RAM_WR) mem[bus.o_RAM_ADDR >> 2] = bus.o_RAM_DATA_WR;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " stall"}, 32'(bus.o_stall), 32'h0);
        check({tag, " done"}, 32'(bus.o_done), 32'h0);
        check({tag, " ce"}, 32'(bus.o_RAM_CE), 32'h0);
        check({tag, " rd"}, 32'(bus.o_RAM_RD), 32'h0);
        check({tag, " wr"}, 32'(bus.o_RAM_WR), 32'h0);
        check({tag, " addr"}, bus.o_RAM_ADDR, 32'h0);
        check({tag, " data_wr"}, bus.o_RAM_DATA_WR, 32'h0);
        check({tag, " rdata"}, bus.o_rdata, 32'h0);
        check({tag, " fault"}, 32'(bus.o_fault), 32'h0);
    endtask

    // Issue one request at a negedge and follow it cycle by cycle until the
    // pipeline is back in idle. Cycle 0 is the accept cycle.
    task automatic do_req(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input int rd_first, input int rd_last,
                          input int wr_cyc, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_fault);
        logic rd_exp;
        logic wr_exp;
        exp_t e;
        bus.i_valid = 1'b1;
        bus.iOpcode = op;
        bus.iFunct3 = f3;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        #1;
        check({name, " accept stall"}, 32'(bus.o_stall), 32'h1);
        check({name, " accept ce"}, 32'(bus.o_RAM_CE), 32'h0);
        sb_q.push_back({exp_rd, exp_fault});
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            rd_exp = (c >= rd_first) && (c <= rd_last);
            wr_exp = (c == wr_cyc);
            check($sformatf("%s c%0d rd", name, c), 32'(bus.o_RAM_RD), 32'(rd_exp));
            check($sformatf("%s c%0d wr", name, c), 32'(bus.o_RAM_WR), 32'(wr_exp));
            check($sformatf("%s c%0d ce", name, c), 32'(bus.o_RAM_CE), 32'(rd_exp | wr_exp));
            check($sformatf("%s c%0d done", name, c), 32'(bus.o_done), 32'(c == lat));
            check($sformatf("%s c%0d stall", name, c), 32'(bus.o_stall), 32'(c < lat));
            if (rd_exp || wr_exp) begin
                check($sformatf("%s c%0d addr", name, c), bus.o_RAM_ADDR, addr & ~32'h3);
            end
            if (wr_exp) begin
                check($sformatf("%s c%0d data_wr", name, c), bus.o_RAM_DATA_WR, exp_wd);
            end
            if (bus.o_done) begin
                if (sb_q.size() == 0) begin
                    check({name, " unexpected done"}, 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check({name, " rdata"}, bus.o_rdata, e.rdata);
                    check({name, " fault"}, 32'(bus.o_fault), 32'(e.fault));
                end
            end
            if (c == 1) begin
                // Request fields are scrambled after accept and must not matter.
                bus.i_valid = 1'b0;
                bus.iOpcode = OP_STORE;
                bus.iFunct3 = F3_W;
                bus.i_addr  = $urandom;
                bus.i_wdata = $urandom;
            end
        end
        check({name, " scoreboard drained"}, 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.iOpcode = 7'h00;
        bus.iFunct3 = 3'b000;
        bus.i_addr  = 32'h0;
        bus.i_wdata = 32'h0;

        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        mem[32'h100 >> 2] = 32'hDEADBEEF;
        do_req("lw", OP_LOAD, F3_W, 32'h100, 32'h0, 3, 1, 2, -1, 32'h0, 32'hDEADBEEF, 1'b0);

        mem[32'h100 >> 2] = 32'h80AABBCC;
        do_req("lb", OP_LOAD, F3_B, 32'h103, 32'h0, 3, 1, 2, -1, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("lbu", OP_LOAD, F3_BU, 32'h103, 32'h0, 3, 1, 2, -1, 32'h0, 32'h00000080, 1'b0);
        do_req("lh", OP_LOAD, F3_H, 32'h102, 32'h0, 3, 1, 2, -1, 32'h0, 32'hFFFF80AA, 1'b0);
        do_req("lhu", OP_LOAD, F3_HU, 32'h100, 32'h0, 3, 1, 2, -1, 32'h0, 32'h0000BBCC, 1'b0);

        mem[32'h200 >> 2] = 32'hAABBCCDD;
        do_req("sb", OP_STORE, F3_B, 32'h202, 32'h12345677, 4, 1, 2, 3, 32'hAA77CCDD,
               32'h0, 1'b0);
        check("sb ram word", mem_rd(32'h200), 32'hAA77CCDD);
        do_req("sh", OP_STORE, F3_H, 32'h200, 32'h1234BEEF, 4, 1, 2, 3, 32'hAA77BEEF,
               32'h0, 1'b0);
        check("sh ram word", mem_rd(32'h200), 32'hAA77BEEF);

        do_req("sw misaligned", OP_STORE, F3_W, 32'h301, 32'h55555555, 1, 1, 0, -1, 32'h0,
               32'h0, 1'b1);
        do_req("lh misaligned", OP_LOAD, F3_H, 32'h101, 32'h0, 1, 1, 0, -1, 32'h0,
               32'h0, 1'b1);
        do_req("load f3 011", OP_LOAD, 3'b011, 32'h100, 32'h0, 1, 1, 0, -1, 32'h0,
               32'h0, 1'b1);

        // Reset in the second read cycle of a halfword store.
        mem[32'h400 >> 2] = 32'h11223344;
        bus.i_valid = 1'b1;
        bus.iOpcode = OP_STORE;
        bus.iFunct3 = F3_H;
        bus.i_addr  = 32'h400;
        bus.i_wdata = 32'h00005555;
        #1;
        check("rst sh accept stall", 32'(bus.o_stall), 32'h1);
        @(negedge clk);
        check("rst sh c1 rd", 32'(bus.o_RAM_RD), 32'h1);
        bus.i_valid = 1'b0;
        @(negedge clk);
        check("rst sh c2 rd", 32'(bus.o_RAM_RD), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("rst sh c3");
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst sh after wr", 32'(bus.o_RAM_WR), 32'h0);
            check("rst sh after ce", 32'(bus.o_RAM_CE), 32'h0);
        end
        check("rst sh ram word", mem_rd(32'h400), 32'h11223344);

        // Non-memory opcode is ignored.
        bus.i_valid = 1'b1;
        bus.iOpcode = 7'h33;
        bus.iFunct3 = F3_W;
        bus.i_addr  = 32'h100;
        #1;
        check("op33 stall", 32'(bus.o_stall), 32'h0);
        check("op33 ce", 32'(bus.o_RAM_CE), 32'h0);
        @(negedge clk);
        check_quiet("op33 next");
        bus.i_valid = 1'b0;

        mem[32'h100 >> 2] = 32'h0BADF00D;
        do_req("b2b lw", OP_LOAD, F3_W, 32'h100, 32'h0, 3, 1, 2, -1, 32'h0, 32'h0BADF00D, 1'b0);
        do_req("b2b sw", OP_STORE, F3_W, 32'h104, 32'hCAFEF00D, 2, 1, 0, 1, 32'hCAFEF00D,
               32'h0, 1'b0);
        do_req("b2b lw2", OP_LOAD, F3_W, 32'h104, 32'h0, 3, 1, 2, -1, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
